// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation classes and datapath select codes.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        s_fetch    = 4'd0,
        s_decode   = 4'd1,
        s_memadr   = 4'd2,
        s_memread  = 4'd3,
        s_memwb    = 4'd4,
        s_memwrite = 4'd5,
        s_executer = 4'd6,
        s_executei = 4'd7,
        s_aluwb    = 4'd8,
        s_beq      = 4'd9,
        s_jal      = 4'd10,
        s_halt     = 4'd11
    } state_t;

    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;
    localparam logic [6:0] op_rtype  = 7'b0110011;
    localparam logic [6:0] op_itype  = 7'b0010011;
    localparam logic [6:0] op_branch = 7'b1100011;
    localparam logic [6:0] op_jal    = 7'b1101111;

    localparam logic [1:0] aluop_add  = 2'b00;
    localparam logic [1:0] aluop_sub  = 2'b01;
    localparam logic [1:0] aluop_func = 2'b10;

    localparam logic [2:0] alu_add = 3'b000;
    localparam logic [2:0] alu_sub = 3'b001;
    localparam logic [2:0] alu_and = 3'b010;
    localparam logic [2:0] alu_or  = 3'b011;
    localparam logic [2:0] alu_slt = 3'b101;

    localparam logic [1:0] res_aluout    = 2'b00;
    localparam logic [1:0] res_data      = 2'b01;
    localparam logic [1:0] res_aluresult = 2'b10;

    localparam logic [1:0] srca_pc    = 2'b00;
    localparam logic [1:0] srca_oldpc = 2'b01;
    localparam logic [1:0] srca_rs1   = 2'b10;

    localparam logic [1:0] srcb_reg  = 2'b00;
    localparam logic [1:0] srcb_imm  = 2'b01;
    localparam logic [1:0] srcb_four = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus funct fields to a concrete ALU control code.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Only R-type (op5=1) with bit 30 set is a subtract; addi ignores bit 30.
    always_comb begin
        alucontrol = alu_add;
        case (aluop)
            aluop_add: alucontrol = alu_add;
            aluop_sub: alucontrol = alu_sub;
            aluop_func: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? alu_sub : alu_add;
                    3'b010:  alucontrol = alu_slt;
                    3'b110:  alucontrol = alu_or;
                    3'b111:  alucontrol = alu_and;
                    default: alucontrol = alu_add;
                endcase
            end
            default: alucontrol = alu_add;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback over a shared ALU and unified memory.
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       halted
);

    state_t     state;
    state_t     cur;
    logic [1:0] aluop;
    logic       branch;
    logic       pcupdate;

    // State register with next-state logic; HALT is left only through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= s_fetch;
        end else begin
            case (state)
                s_fetch:    if (mem_ready) state <= s_decode;
                s_decode: begin
                    case (op)
                        op_load, op_store: state <= s_memadr;
                        op_rtype:          state <= s_executer;
                        op_itype:          state <= s_executei;
                        op_branch:         state <= s_beq;
                        op_jal:            state <= s_jal;
                        default:           state <= s_halt;
                    endcase
                end
                s_memadr:   state <= op[5] ? s_memwrite : s_memread;
                s_memread:  if (mem_ready) state <= s_memwb;
                s_memwb:    state <= s_fetch;
                s_memwrite: if (mem_ready) state <= s_fetch;
                s_executer: state <= s_aluwb;
                s_executei: state <= s_aluwb;
                s_aluwb:    state <= s_fetch;
                s_beq:      state <= s_fetch;
                s_jal:      state <= s_aluwb;
                s_halt:     state <= s_halt;
                default:    state <= s_fetch;
            endcase
        end
    end

    // Moore output decode. While reset is high the FETCH selects are shown
    // with every enable held low, whatever the state register holds.
    always_comb begin
        cur       = reset ? s_fetch : state;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = res_aluout;
        ALUSrcA   = srca_pc;
        ALUSrcB   = srcb_reg;
        aluop     = aluop_add;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        halted    = 1'b0;
        case (cur)
            s_fetch: begin
                ResultSrc = res_aluresult;
                ALUSrcB   = srcb_four;
                IRWrite   = mem_ready & ~reset;
                pcupdate  = mem_ready & ~reset;
            end
            s_decode: begin
                ALUSrcA = srca_oldpc;
                ALUSrcB = srcb_imm;
            end
            s_memadr: begin
                ALUSrcA = srca_rs1;
                ALUSrcB = srcb_imm;
            end
            s_memread:  AdrSrc = 1'b1;
            s_memwb: begin
                ResultSrc = res_data;
                RegWrite  = 1'b1;
            end
            s_memwrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            s_executer: begin
                ALUSrcA = srca_rs1;
                aluop   = aluop_func;
            end
            s_executei: begin
                ALUSrcA = srca_rs1;
                ALUSrcB = srcb_imm;
                aluop   = aluop_func;
            end
            s_aluwb:    RegWrite = 1'b1;
            s_beq: begin
                ALUSrcA = srca_rs1;
                aluop   = aluop_sub;
                branch  = 1'b1;
            end
            s_jal: begin
                ALUSrcA  = srca_oldpc;
                ALUSrcB  = srcb_four;
                pcupdate = 1'b1;
            end
            s_halt:     halted = 1'b1;
            default: ;
        endcase
    end

    assign PCWrite = pcupdate | (branch & zero);

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            op_load, op_itype: ImmSrc = 2'b00;
            op_store:          ImmSrc = 2'b01;
            op_branch:         ImmSrc = 2'b10;
            op_jal:            ImmSrc = 2'b11;
            default:           ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle check of the multicycle controller outputs against
// hand-written expected values for each instruction class.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    // packed: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,halted}
    typedef struct {
        bit         rst;
        logic [6:0] op;
        logic [2:0] f3;
        bit         f7;
        bit         z;
        bit         mr;
        logic [16:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        string       name;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [1:0] imm(input logic [6:0] o);
        case (o)
            SW:      return 2'b01;
            BQ:      return 2'b10;
            JL:      return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [16:0] eo(input bit pcw, input bit adr, input bit mw,
                                       input bit irw, input bit rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [6:0] o, input logic [2:0] ctl, input bit h);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm(o), ctl, h};
    endfunction

    // Expected outputs per FSM state, written from the state table.
    function automatic logic [16:0] e_rst(input logic [6:0] o);            return eo(0,0,0,0,0,2'b10,2'b00,2'b10,o,3'b000,0); endfunction
    function automatic logic [16:0] e_f(input logic [6:0] o, input bit mr); return eo(mr,0,0,mr,0,2'b10,2'b00,2'b10,o,3'b000,0); endfunction
    function automatic logic [16:0] e_d(input logic [6:0] o);              return eo(0,0,0,0,0,2'b00,2'b01,2'b01,o,3'b000,0); endfunction
    function automatic logic [16:0] e_ma(input logic [6:0] o);             return eo(0,0,0,0,0,2'b00,2'b10,2'b01,o,3'b000,0); endfunction
    function automatic logic [16:0] e_mr(input logic [6:0] o);             return eo(0,1,0,0,0,2'b00,2'b00,2'b00,o,3'b000,0); endfunction
    function automatic logic [16:0] e_mwb(input logic [6:0] o);            return eo(0,0,0,0,1,2'b01,2'b00,2'b00,o,3'b000,0); endfunction
    function automatic logic [16:0] e_mw(input logic [6:0] o);             return eo(0,1,1,0,0,2'b00,2'b00,2'b00,o,3'b000,0); endfunction
    function automatic logic [16:0] e_xr(input logic [6:0] o, input logic [2:0] c); return eo(0,0,0,0,0,2'b00,2'b10,2'b00,o,c,0); endfunction
    function automatic logic [16:0] e_xi(input logic [6:0] o, input logic [2:0] c); return eo(0,0,0,0,0,2'b00,2'b10,2'b01,o,c,0); endfunction
    function automatic logic [16:0] e_wb(input logic [6:0] o);             return eo(0,0,0,0,1,2'b00,2'b00,2'b00,o,3'b000,0); endfunction
    function automatic logic [16:0] e_bq(input logic [6:0] o, input bit z); return eo(z,0,0,0,0,2'b00,2'b10,2'b00,o,3'b001,0); endfunction
    function automatic logic [16:0] e_jl(input logic [6:0] o);             return eo(1,0,0,0,0,2'b00,2'b01,2'b10,o,3'b000,0); endfunction
    function automatic logic [16:0] e_h(input logic [6:0] o);              return eo(0,0,0,0,0,2'b00,2'b00,2'b00,o,3'b000,1); endfunction

    task automatic add(input bit rst, input logic [6:0] o, input logic [2:0] f3, input bit f7,
                       input bit z, input bit mr, input logic [16:0] e, input string nm);
        vec_t v;
        v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    // One cycle: drive after the edge, queue the expectation, compare mid-cycle.
    task automatic step(input vec_t v);
        sb_t s;
        logic [16:0] act;
        @(posedge clk);
        #1;
        reset = v.rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z; mem_ready = v.mr;
        s.exp = v.exp; s.name = v.name;
        sb.push_back(s);
        @(negedge clk);
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, halted};
        s = sb.pop_front();
        total++;
        if (act !== s.exp) begin
            bad++;
            $display("FAIL %s: got %05h want %05h", s.name, act, s.exp);
        end
    endtask

    task automatic step1(input bit rst, input logic [6:0] o, input logic [2:0] f3, input bit f7,
                         input bit z, input bit mr, input logic [16:0] e, input string nm);
        vec_t v;
        v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e; v.name = nm;
        step(v);
    endtask

    initial begin
        // reset
        add(1, RT, 0, 0, 0, 1, e_rst(RT), "reset0");
        add(1, RT, 0, 0, 0, 1, e_rst(RT), "reset1");
        // add
        add(0, RT, 3'b000, 0, 0, 1, e_f(RT,1), "add_fetch");
        add(0, RT, 3'b000, 0, 0, 1, e_d(RT), "add_decode");
        add(0, RT, 3'b000, 0, 0, 1, e_xr(RT,3'b000), "add_exec");
        add(0, RT, 3'b000, 0, 0, 1, e_wb(RT), "add_wb");
        // sub
        add(0, RT, 3'b000, 1, 0, 1, e_f(RT,1), "sub_fetch");
        add(0, RT, 3'b000, 1, 0, 1, e_d(RT), "sub_decode");
        add(0, RT, 3'b000, 1, 0, 1, e_xr(RT,3'b001), "sub_exec");
        add(0, RT, 3'b000, 1, 0, 1, e_wb(RT), "sub_wb");
        // addi with bit30 set stays add
        add(0, IT, 3'b000, 1, 0, 1, e_f(IT,1), "addi_fetch");
        add(0, IT, 3'b000, 1, 0, 1, e_d(IT), "addi_decode");
        add(0, IT, 3'b000, 1, 0, 1, e_xi(IT,3'b000), "addi_exec");
        add(0, IT, 3'b000, 1, 0, 1, e_wb(IT), "addi_wb");
        // slt, and (R); ori, xori-class (I)
        add(0, RT, 3'b010, 0, 0, 1, e_f(RT,1), "slt_fetch");
        add(0, RT, 3'b010, 0, 0, 1, e_d(RT), "slt_decode");
        add(0, RT, 3'b010, 0, 0, 1, e_xr(RT,3'b101), "slt_exec");
        add(0, RT, 3'b010, 0, 0, 1, e_wb(RT), "slt_wb");
        add(0, RT, 3'b111, 0, 0, 1, e_f(RT,1), "and_fetch");
        add(0, RT, 3'b111, 0, 0, 1, e_d(RT), "and_decode");
        add(0, RT, 3'b111, 0, 0, 1, e_xr(RT,3'b010), "and_exec");
        add(0, RT, 3'b111, 0, 0, 1, e_wb(RT), "and_wb");
        add(0, IT, 3'b110, 0, 0, 1, e_f(IT,1), "ori_fetch");
        add(0, IT, 3'b110, 0, 0, 1, e_d(IT), "ori_decode");
        add(0, IT, 3'b110, 0, 0, 1, e_xi(IT,3'b011), "ori_exec");
        add(0, IT, 3'b110, 0, 0, 1, e_wb(IT), "ori_wb");
        add(0, IT, 3'b100, 0, 0, 1, e_f(IT,1), "xori_fetch");
        add(0, IT, 3'b100, 0, 0, 1, e_d(IT), "xori_decode");
        add(0, IT, 3'b100, 0, 0, 1, e_xi(IT,3'b000), "xori_exec");
        add(0, IT, 3'b100, 0, 0, 1, e_wb(IT), "xori_wb");
        // beq taken (zero high in decode must not write PC), then not taken
        add(0, BQ, 3'b000, 0, 1, 1, e_f(BQ,1), "beqt_fetch");
        add(0, BQ, 3'b000, 0, 1, 1, e_d(BQ), "beqt_decode");
        add(0, BQ, 3'b000, 0, 1, 1, e_bq(BQ,1), "beqt_beq");
        add(0, BQ, 3'b000, 0, 0, 1, e_f(BQ,1), "beqn_fetch");
        add(0, BQ, 3'b000, 0, 0, 1, e_d(BQ), "beqn_decode");
        add(0, BQ, 3'b000, 0, 0, 1, e_bq(BQ,0), "beqn_beq");
        // jal
        add(0, JL, 3'b000, 0, 0, 1, e_f(JL,1), "jal_fetch");
        add(0, JL, 3'b000, 0, 0, 1, e_d(JL), "jal_decode");
        add(0, JL, 3'b000, 0, 0, 1, e_jl(JL), "jal_jal");
        add(0, JL, 3'b000, 0, 0, 1, e_wb(JL), "jal_wb");
        // lw, 3 wait cycles in MEMREAD; mem_ready low in decode is ignored
        add(0, LW, 3'b010, 0, 0, 1, e_f(LW,1), "lw_fetch");
        add(0, LW, 3'b010, 0, 0, 0, e_d(LW), "lw_decode");
        add(0, LW, 3'b010, 0, 0, 0, e_ma(LW), "lw_memadr");
        add(0, LW, 3'b010, 0, 0, 0, e_mr(LW), "lw_wait1");
        add(0, LW, 3'b010, 0, 0, 0, e_mr(LW), "lw_wait2");
        add(0, LW, 3'b010, 0, 0, 0, e_mr(LW), "lw_wait3");
        add(0, LW, 3'b010, 0, 0, 1, e_mr(LW), "lw_read");
        add(0, LW, 3'b010, 0, 0, 1, e_mwb(LW), "lw_wb");
        // sw, 2 wait cycles: MemWrite high three cycles
        add(0, SW, 3'b010, 0, 0, 1, e_f(SW,1), "sw_fetch");
        add(0, SW, 3'b010, 0, 0, 1, e_d(SW), "sw_decode");
        add(0, SW, 3'b010, 0, 0, 1, e_ma(SW), "sw_memadr");
        add(0, SW, 3'b010, 0, 0, 0, e_mw(SW), "sw_wait1");
        add(0, SW, 3'b010, 0, 0, 0, e_mw(SW), "sw_wait2");
        add(0, SW, 3'b010, 0, 0, 1, e_mw(SW), "sw_write");
        // fetch stall
        add(0, RT, 3'b000, 0, 0, 0, e_f(RT,0), "stall_f1");
        add(0, RT, 3'b000, 0, 0, 0, e_f(RT,0), "stall_f2");
        add(0, RT, 3'b000, 0, 0, 1, e_f(RT,1), "stall_f3");
        add(0, RT, 3'b000, 0, 0, 1, e_d(RT), "stall_decode");
        add(0, RT, 3'b000, 0, 0, 1, e_xr(RT,3'b000), "stall_exec");
        add(0, RT, 3'b000, 0, 0, 1, e_wb(RT), "stall_wb");

        foreach (tbl[i]) step(tbl[i]);

        // illegal opcode: halt and hold with every enable low
        step1(0, BAD, 0, 0, 1, 1, e_f(BAD,1), "ill_fetch");
        step1(0, BAD, 0, 0, 1, 1, e_d(BAD), "ill_decode");
        for (int k = 0; k < 12; k++)
            step1(0, BAD, 0, 0, 1, 1, e_h(BAD), $sformatf("halt_%0d", k));
        step1(1, BAD, 0, 0, 1, 1, e_rst(BAD), "halt_reset");
        step1(0, RT, 0, 0, 0, 1, e_f(RT,1), "after_halt_fetch");
        step1(0, RT, 0, 0, 0, 1, e_d(RT), "after_halt_decode");
        step1(0, RT, 0, 0, 0, 1, e_xr(RT,3'b000), "after_halt_exec");
        step1(0, RT, 0, 0, 0, 1, e_wb(RT), "after_halt_wb");

        // reset in the middle of a store wait aborts the write
        step1(0, SW, 0, 0, 0, 1, e_f(SW,1), "swr_fetch");
        step1(0, SW, 0, 0, 0, 1, e_d(SW), "swr_decode");
        step1(0, SW, 0, 0, 0, 1, e_ma(SW), "swr_memadr");
        step1(0, SW, 0, 0, 0, 0, e_mw(SW), "swr_wait");
        step1(1, SW, 0, 0, 0, 0, e_rst(SW), "swr_reset");
        step1(0, SW, 0, 0, 0, 0, e_f(SW,0), "swr_refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RISC-V datapath (RV32I subset: lw, sw, R-type, I-type ALU, beq, jal). It sequences a shared ALU and a unified instruction/data memory across several cycles per instruction. It drives the datapath's mux selects and write enables. It stalls on a memory ready handshake and halts on an illegal opcode.

## Interface
Parameters:
- none; all encodings are constants in the shared package.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode, from the instruction register
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register A
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate type
- ALUControl  out  3  ALU operation
- halted  out  1  high while the FSM is in HALT

## Operation
Outputs are Moore outputs decoded from the state register. There are two exceptions: PCWrite and the memory-gated enables (see FETCH and the memory states). Every output not listed for a state is 0.

States, with 4-bit encodings, outputs and transitions:
- FETCH (0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only when mem_ready=1.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes the branch target).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other value -> HALT.
- MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
- MEMREAD (3): AdrSrc=1, ResultSrc=00. Stay until mem_ready=1, then -> MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE (5): AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite is held high until mem_ready=1, then -> FETCH.
- EXECUTER (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB (8): ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ (9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- JAL (10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- HALT (11): halted=1 and all enables 0. Stays in HALT until reset.

Derived outputs:
- PCWrite = PCUpdate | (Branch & zero).
- ImmSrc is combinational from op: 0000011/0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other op -> 00.
- ALUControl comes from the alu_decoder:
  - ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
  - ALUOp 10, by funct3: 000 -> 001 if (op[5] & funct7b5) else 000; 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); any other funct3 -> 000.
  - ALUOp 11 -> 000.

## Timing
- Reset:
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 and halted=0. The mux selects show the FETCH values.
  - On the first edge with reset=1, the state becomes FETCH. Reset asserted in any state, including HALT or a memory wait, aborts the instruction with no write.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Write enables are single-cycle pulses, except MemWrite, which is held for the whole MEMWRITE wait.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- beq: PCWrite is asserted in the BEQ cycle only if zero=1 in that same cycle.

## Structure
- Package `riscv_mc_pkg` holds:
  - the state enum (4-bit);
  - opcode constants;
  - the ALUOp codes, ALUControl codes, and ResultSrc/ALUSrcA/ALUSrcB select codes.
- Sub-module `alu_decoder` (combinational; inputs ALUOp, funct3, op[5], funct7b5).
- The controller holds the state register, next-state logic, output decode and the ImmSrc decode.

## Test plan
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB. ALUControl=000 in EXECUTER; RegWrite=1 only in the 4th cycle.
- sub (funct7b5=1) -> ALUControl=001 in EXECUTER. addi with funct7b5=1 (op 0010011) -> ALUControl=000.
- lw with mem_ready held 0 for 3 cycles in MEMREAD -> 8 cycles total. RegWrite with ResultSrc=01 is asserted exactly once.
- sw, mem_ready=0 for 2 cycles -> MemWrite high for 3 consecutive cycles, then FETCH. RegWrite is never asserted.
- beq with zero=1 -> PCWrite=1 in BEQ, 3 cycles total. With zero=0 -> PCWrite=0 in BEQ.
- op=0000000 -> HALT after DECODE, halted=1, all enables 0 for 10+ cycles. Reset pulse -> FETCH with halted=0. Reset during MEMWRITE -> MemWrite=0 in that cycle and FETCH next.
